// File: rtl/bram_stream_reader_pkg.sv
// Shared types and limits for the BRAM stream reader.
package bram_rd_pkg;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Deepest BRAM read latency the in-flight tracking supports.
    localparam int RD_LAT_MAX = 2;

endpackage

// File: rtl/bram_stream_reader_if.sv
// Valid/ready word stream carrying a last-word marker.
interface bram_stream_if #(
    parameter int DATA_W = 32
);
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              last;
    logic              ready;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/bram_stream_reader_fifo.sv
// Synchronous FIFO buffering BRAM read data ahead of the stream consumer.
// Push and pop may occur in the same cycle; occupancy is exported so the
// producer can do credit-based flow control (no internal overflow guard).
module bram_rd_fifo #(
    parameter  int WIDTH = 33,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW:0]      count_q, count_d;

    // Next pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_comb begin
        wr_d    = push ? wr_q + AW'(1) : wr_q;
        rd_d    = pop  ? rd_q + AW'(1) : rd_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents need no reset because occupancy gates them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_q];
    assign empty = (count_q == '0);
    assign count = count_q;
endmodule

// File: rtl/bram_stream_reader.sv
// BRAM read-side sequencer: walks base_addr..base_addr+length-1 (wrapping)
// and streams the words out with a last-word marker. A credit check on
// FIFO occupancy plus in-flight reads keeps the output FIFO from overflowing.
// Optional feature macro: BRAM_RD_CHECKSUM_EN adds a running checksum port.
module bram_stream_reader
    import bram_rd_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [DATA_W-1:0] bram_dout,
    bram_stream_if.master     m
`ifdef BRAM_RD_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int INF_W = $clog2(RD_LAT_MAX + 1);

    if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
        $error("bram_stream_reader: RD_LAT must be 1 or 2");
    end
    if (FIFO_DEPTH < RD_LAT + 1 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("bram_stream_reader: FIFO_DEPTH must be a power of 2 and >= RD_LAT+1");
    end

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     base_q, base_d;
    logic [ADDR_W:0]       len_q, len_d;
    logic [ADDR_W:0]       issued_q, issued_d;
    logic [RD_LAT_MAX-1:0] vld_q, vld_d;
    logic [RD_LAT_MAX-1:0] last_q, last_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [INF_W-1:0]      inflight;
    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W:0]        occupancy;
    logic                  issue;
    logic                  issue_last;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_empty;
    logic [DATA_W:0]       fifo_dout;

    // Reads issued but not yet landed in the FIFO.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT_MAX; i++) begin
            inflight = inflight + INF_W'(vld_q[i]);
        end
    end

    assign occupancy  = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(inflight);
    assign issue      = (state_q == RUN) && (issued_q < len_q) &&
                        (occupancy < (CNT_W+1)'(FIFO_DEPTH));
    assign issue_last = (issued_q == len_q - (ADDR_W+1)'(1));
    assign bram_en    = issue;
    assign bram_addr  = issue ? base_q + issued_q[ADDR_W-1:0] : '0;

    assign fifo_push  = vld_q[RD_LAT-1];
    assign fifo_pop   = m.valid & m.ready;

    // Next-state, issue counter and read-tracking shift register.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        len_d    = len_q;
        issued_d = issued_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d   = base_addr;
                    len_d    = length;
                    issued_d = '0;
                    state_d  = (length == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (issue) begin
                    issued_d = issued_q + (ADDR_W+1)'(1);
                end
                if (issued_q == len_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_pop && fifo_dout[DATA_W]) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        vld_d     = '0;
        last_d    = '0;
        vld_d[0]  = issue;
        last_d[0] = issue & issue_last;
        for (int i = 1; i < RD_LAT_MAX; i++) begin
            vld_d[i]  = (i < RD_LAT) ? vld_q[i-1]  : 1'b0;
            last_d[i] = (i < RD_LAT) ? last_q[i-1] : 1'b0;
        end

        busy_d = (state_d == RUN) || (state_d == DRAIN);
        done_d = (state_d == DONE);
    end

    // Sequencer registers; reset also drops any read still in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            base_q   <= '0;
            len_q    <= '0;
            issued_q <= '0;
            vld_q    <= '0;
            last_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            len_q    <= len_d;
            issued_q <= issued_d;
            vld_q    <= vld_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

    bram_rd_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   ({last_q[RD_LAT-1], bram_dout}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Stale FIFO contents are masked so an idle stream drives zeros.
    assign m.valid = ~fifo_empty;
    assign m.data  = m.valid ? fifo_dout[DATA_W-1:0] : '0;
    assign m.last  = m.valid & fifo_dout[DATA_W];

`ifdef BRAM_RD_CHECKSUM_EN
    logic [DATA_W-1:0] cks_q, cks_d;

    // Running sum of handed-off words, cleared when a transfer is accepted.
    always_comb begin
        cks_d = cks_q;
        if (state_q == IDLE && start) begin
            cks_d = '0;
        end else if (fifo_pop) begin
            cks_d = cks_q + fifo_dout[DATA_W-1:0];
        end
    end

    // Checksum register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cks_q <= '0;
        end else begin
            cks_q <= cks_d;
        end
    end

    assign checksum = cks_q;
`endif
endmodule

// File: tb/tb_bram_stream_reader.sv
// Scoreboard bench for bram_stream_reader: stimulus pushes expected words,
// a negedge monitor pops and compares on every handshake.
module tb_bram_stream_reader;
    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 32;
    localparam int RD_LAT     = 1;
    localparam int FIFO_DEPTH = 4;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   length;
    logic              busy;
    logic              done;
    logic              bram_en;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_dout;
`ifdef BRAM_RD_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;
    logic [DATA_W-1:0] cks_at_done;
`endif

    bram_stream_if #(.DATA_W(DATA_W)) s_if ();

    bram_stream_reader #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .RD_LAT     (RD_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .bram_en   (bram_en),
        .bram_addr (bram_addr),
        .bram_dout (bram_dout),
        .m         (s_if.master)
`ifdef BRAM_RD_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    always #5 clk = ~clk;

    // BRAM model with one cycle read latency
    logic [DATA_W-1:0] mem [1024];
    always @(posedge clk) if (bram_en) bram_dout <= mem[bram_addr];

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    exp_t sb[$];
    logic [ADDR_W-1:0] addr_q[$];
    int hs_cnt = 0, en_cnt = 0, done_cnt = 0;
    int first_valid_cyc, first_hs_cyc, last_cyc, done_cyc;
    bit first_valid_seen = 0, first_hs_seen = 0;
    int max_out = 0;

    // Consumer ready: level, or 1 cycle on / 3 off
    bit tog = 0;
    int ph = 0;
    always @(posedge clk) begin
        #1;
        if (tog) begin
            s_if.ready = (ph % 4 == 0);
            ph++;
        end
    end

    // Monitor / scoreboard checker
    always @(negedge clk) begin
        if (!reset) begin
            if (bram_en) begin
                en_cnt++;
                addr_q.push_back(bram_addr);
            end
            if (en_cnt - hs_cnt > max_out) max_out = en_cnt - hs_cnt;
            if (s_if.valid && !first_valid_seen) begin
                first_valid_seen = 1;
                first_valid_cyc  = cyc;
            end
            if (s_if.valid && s_if.ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("m_data", s_if.data, e.data);
                    chk("m_last", s_if.last, e.last);
                end
                if (!first_hs_seen) begin
                    first_hs_seen = 1;
                    first_hs_cyc  = cyc;
                end
                if (s_if.last) last_cyc = cyc;
                hs_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
`ifdef BRAM_RD_CHECKSUM_EN
                cks_at_done = checksum;
`endif
            end
        end
    end

    int start_cyc;

    task automatic start_xfer(input int base, input int len);
        for (int i = 0; i < len; i++) begin
            exp_t e;
            e.data = mem[(base + i) % 1024];
            e.last = (i == len - 1);
            sb.push_back(e);
        end
        first_valid_seen = 0;
        first_hs_seen    = 0;
        addr_q.delete();
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = ADDR_W'(base);
        length    = (ADDR_W+1)'(len);
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int dn0);
        int n = 0;
        while (done_cnt == dn0 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, done_cnt - dn0, 1);
        @(posedge clk); #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_en"},    bram_en, 0);
        chk({tag, "_addr"},  bram_addr, 0);
        chk({tag, "_valid"}, s_if.valid, 0);
        chk({tag, "_data"},  s_if.data, 0);
        chk({tag, "_last"},  s_if.last, 0);
    endtask

    initial begin
        int dn0, en0, hs0, n;
        for (int i = 0; i < 1024; i++) mem[i] = DATA_W'(i + 1);
        bram_dout  = '0;
        reset      = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        length     = '0;
        s_if.ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_idle("reset");
        reset = 1'b0;

        // 1: base 0, len 4, full throughput
        dn0 = done_cnt; hs0 = hs_cnt;
        start_xfer(0, 4);
        wait_done("t1_done", dn0);
        chk("t1_first_valid_lat", first_valid_cyc - start_cyc, 3);
        chk("t1_burst_span", last_cyc - first_hs_cyc, 3);
        chk("t1_done_after_last", done_cyc - last_cyc, 1);
        chk("t1_words", hs_cnt - hs0, 4);
        chk("t1_sb_empty", sb.size(), 0);

        // 2: zero length
        dn0 = done_cnt; en0 = en_cnt;
        start_xfer(0, 0);
        wait_done("t2_done", dn0);
        chk("t2_done_cycle", done_cyc - start_cyc, 1);
        chk("t2_no_en", en_cnt - en0, 0);
        chk("t2_no_valid", first_valid_seen, 0);

        // 3: address wrap from 1022
        dn0 = done_cnt;
        start_xfer(1022, 4);
        wait_done("t3_done", dn0);
        chk("t3_naddr", addr_q.size(), 4);
        if (addr_q.size() == 4) begin
            chk("t3_addr0", addr_q[0], 1022);
            chk("t3_addr1", addr_q[1], 1023);
            chk("t3_addr2", addr_q[2], 0);
            chk("t3_addr3", addr_q[3], 1);
        end
        chk("t3_sb_empty", sb.size(), 0);

        // 4: backpressure 1 on / 3 off
        ph = 0; tog = 1; max_out = 0;
        dn0 = done_cnt; en0 = en_cnt; hs0 = hs_cnt;
        start_xfer(100, 16);
        wait_done("t4_done", dn0);
        tog = 0;
        s_if.ready = 1'b1;
        chk("t4_words", hs_cnt - hs0, 16);
        chk("t4_reads", en_cnt - en0, 16);
        chk("t4_credit", (max_out <= FIFO_DEPTH), 1);
        chk("t4_sb_empty", sb.size(), 0);

        // 5: reset during the 3rd handshake of len 8
        dn0 = done_cnt; hs0 = hs_cnt;
        start_xfer(0, 8);
        n = 0;
        while (hs_cnt < hs0 + 2 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t5_reach_hs2", hs_cnt - hs0, 2);
        reset = 1'b1;
        @(posedge clk); #1;
        chk_idle("t5_rst");
        sb.delete();
        reset = 1'b0;
        chk("t5_no_done", done_cnt - dn0, 0);
        dn0 = done_cnt; hs0 = hs_cnt;
        start_xfer(10, 2);
        wait_done("t5b_done", dn0);
        repeat (3) @(posedge clk);
        #1;
        chk("t5b_words", hs_cnt - hs0, 2);
        chk("t5b_sb_empty", sb.size(), 0);

`ifdef BRAM_RD_CHECKSUM_EN
        // 6: checksum wraps mod 2^32
        mem[0] = 32'hFFFF_FFFF;
        mem[1] = 32'd1;
        mem[2] = 32'd5;
        dn0 = done_cnt;
        start_xfer(0, 3);
        wait_done("t6_done", dn0);
        chk("t6_cks_at_done", cks_at_done, 5);
        repeat (2) @(posedge clk);
        #1;
        chk("t6_cks_held", checksum, 5);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
